// File: rtl/neuron_pkg.sv
// neuron_pkg: shared defaults for the neuron spike-processing blocks.
package neuron_pkg;

    localparam int ISI_W_DEF      = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [ISI_W_DEF-1:0] ISI_SAT = '1;

endpackage

// File: rtl/spike_sync_fifo.sv
// spike_sync_fifo: single-clock first-word-fall-through FIFO with async reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spike_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wr_data_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = count_q == '0;
    assign full_o    = count_q == (AW+1)'(DEPTH);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spike_isi_recorder.sv
// spike_isi_recorder: detects spike onsets, measures inter-spike intervals in
// enabled cycles and queues them on a valid/ready port with count and overflow.
module spike_isi_recorder
    import neuron_pkg::*;
#(
    parameter int ISI_W = ISI_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             spike,
    input  logic             enable,
    input  logic             clear_ovf,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ISI_W-1:0] rd_data,
    output logic [CNT_W-1:0] spike_count,
    output logic             overflow
);

    localparam logic [ISI_W-1:0] SAT = '1;

    logic             spike_q;
    logic             armed_q;
    logic             armed_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ISI_W-1:0] timer_q;
    logic [ISI_W-1:0] timer_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             onset;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign rd_valid    = ~empty;
    assign spike_count = cnt_q;
    assign overflow    = ovf_q;

    // The first onset only arms the timer; later onsets push the elapsed count.
    always_comb begin
        onset   = enable & spike & ~spike_q;
        push    = onset & armed_q;
        pop     = rd_valid & rd_ready;
        timer_d = !enable ? timer_q :
                  onset ? ISI_W'(1) :
                  (armed_q && timer_q != SAT) ? timer_q + ISI_W'(1) : timer_q;
        armed_d = armed_q | onset;
        cnt_d   = cnt_q + CNT_W'(onset);
        ovf_d   = (push & full & ~pop) | (ovf_q & ~clear_ovf);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spike_q <= 1'b0;
            armed_q <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            spike_q <= spike;
            armed_q <= armed_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    spike_sync_fifo #(
        .W     (ISI_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (timer_q),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty)
    );

endmodule

// File: tb/tb_spike_isi_recorder.sv
// tb_spike_isi_recorder: directed and random stimulus on a 16-bit and a 4-bit
// ISI recorder driven in parallel, checked against an interval/queue model.
module tb_spike_isi_recorder;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spike = 1'b0;
    logic        enable = 1'b1;
    logic        clear_ovf = 1'b0;
    logic        rd_ready = 1'b1;
    logic        rv16, ov16, rv4, ov4;
    logic [15:0] rd16, sc16, sc4;
    logic [3:0]  rd4;

    int checks = 0;
    int failures = 0;

    // Model: intervals measured in enabled clock edges between onsets.
    int          mq[$];
    logic        m_prev = 1'b0;
    logic        m_armed = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;
    int          ecnt = 0;
    int          last = 0;
    logic        m_onset;
    logic        m_drop;

    int p16[$];
    int p4[$];

    always #5 clock = ~clock;

    spike_isi_recorder #(.ISI_W(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .spike(spike), .enable(enable),
        .clear_ovf(clear_ovf), .rd_valid(rv16), .rd_ready(rd_ready),
        .rd_data(rd16), .spike_count(sc16), .overflow(ov16));

    spike_isi_recorder #(.ISI_W(4), .DEPTH(DEPTH), .CNT_W(16)) dut4 (
        .clock(clock), .reset(reset), .spike(spike), .enable(enable),
        .clear_ovf(clear_ovf), .rd_valid(rv4), .rd_ready(rd_ready),
        .rd_data(rd4), .spike_count(sc4), .overflow(ov4));

    function automatic longint sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_prev = 1'b0; m_armed = 1'b0; m_ovf = 1'b0; m_cnt = '0;
            ecnt = 0; last = 0;
        end else begin
            m_onset = enable && spike && !m_prev;
            m_prev = spike;
            if (enable) ecnt++;
            if (rd_ready && mq.size() > 0) void'(mq.pop_front());
            m_drop = 1'b0;
            if (m_onset) begin
                m_cnt++;
                if (m_armed) begin
                    if (mq.size() < DEPTH) mq.push_back(ecnt - last);
                    else m_drop = 1'b1;
                end
                m_armed = 1'b1;
                last = ecnt;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("rd_valid16", rv16, mq.size() != 0);
            chk("rd_valid4", rv4, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rd_data16", rd16, sat(mq[0], 16));
                chk("rd_data4", rd4, sat(mq[0], 4));
            end
            chk("count16", sc16, m_cnt);
            chk("count4", sc4, m_cnt);
            chk("overflow16", ov16, m_ovf);
            chk("overflow4", ov4, m_ovf);
            if (rv16 && rd_ready) p16.push_back(int'(rd16));
            if (rv4 && rd_ready) p4.push_back(int'(rd4));
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        spike = 1'b0; clear_ovf = 1'b0; enable = 1'b1;
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        p16.delete();
        p4.delete();
    endtask

    task automatic pulse(input int gap_after);
        spike = 1'b1;
        run(1);
        spike = 1'b0;
        run(gap_after);
    endtask

    initial begin
        int bad;
        int tdiv;
        #12;
        chk("reset_rd_valid", rv16, 0);
        chk("reset_rd_data", rd16, 0);
        chk("reset_count", sc16, 0);
        chk("reset_overflow", ov16, 0);
        chk("reset_rd_data4", rd4, 0);

        // Onsets 15 then 6 edges apart, drained immediately.
        do_reset();
        rd_ready = 1'b1;
        pulse(14);
        pulse(5);
        pulse(4);
        chk("A_pops", p16.size(), 2);
        chk("A_isi0", p16[0], 15);
        chk("A_isi1", p16[1], 6);
        chk("A_isi0_w4", p4[0], 15);
        chk("A_isi1_w4", p4[1], 6);
        chk("A_count", sc16, 3);
        chk("A_overflow", ov16, 0);

        // Held-high spike is one onset; gap 30 saturates the 4-bit timer.
        do_reset();
        spike = 1'b1;
        run(10);
        spike = 1'b0;
        run(20);
        pulse(3);
        chk("B_pops", p16.size(), 1);
        chk("B_isi", p16[0], 30);
        chk("B_isi_w4_sat", p4[0], 15);
        chk("B_count", sc16, 2);

        // Overflow with ready low, then full FIFO push with a same-cycle pop.
        do_reset();
        rd_ready = 1'b0;
        repeat (10) pulse(4);
        chk("C_overflow_set", ov16, 1);
        chk("C_model_occ", mq.size(), 8);
        chk("C_rd_valid", rv16, 1);
        clear_ovf = 1'b1;
        rd_ready = 1'b1;
        spike = 1'b1;
        run(1);
        clear_ovf = 1'b0;
        spike = 1'b0;
        chk("C_full_pop_no_ovf", ov16, 0);
        chk("C_full_pop_occ", mq.size(), 8);
        run(10);
        chk("C_drain_n", p16.size(), 9);
        bad = 0;
        foreach (p16[i]) bad += (p16[i] != 5) ? 1 : 0;
        chk("C_drain_vals", bad, 0);
        chk("C_drain_empty", rv16, 0);
        chk("C_count", sc16, 11);

        // Asynchronous reset with 3 words buffered.
        do_reset();
        rd_ready = 1'b0;
        pulse(2);
        pulse(2);
        pulse(2);
        pulse(2);
        chk("D_buffered", rv16, 1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("D_async_rd_valid", rv16, 0);
        chk("D_async_count", sc16, 0);
        chk("D_async_overflow", ov16, 0);
        chk("D_async_rd_valid4", rv4, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        pulse(3);
        chk("D_first_no_push", rv16, 0);
        chk("D_first_count", sc16, 1);
        pulse(2);
        chk("D_second_push", rv16, 1);
        chk("D_second_isi", rd16, 4);

        // Random phases with varying spike density, stalls and enable gaps.
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            tdiv = 2 + 6 * ph;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, tdiv - 1) == 0) spike = ~spike;
                enable = $urandom_range(0, 15) != 0;
                rd_ready = (ph % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
                clear_ovf = $urandom_range(0, 63) == 0;
                reset = $urandom_range(0, 1499) == 0;
                run(1);
            end
        end
        reset = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
